// File: rtl/serial_sink_to_memory.sv
// Receives start-bit framed serial flits, deserializes {payload, dest} and queues them in a show-ahead FIFO.
// Latency: start bit at edge 0, data at edges 1..FW, stored at edge FW+1, head visible right after it.
// Backpressure: registered busy reserves the last slot for an in-flight frame; frames arriving while full are dropped.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif

module serial_sink_to_memory #(
  parameter int id    = -1,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 serial_in,
  output logic                                 busy,
  input  logic                                 rd_en,
  output logic                                 rd_valid,
  output logic [`PAYLOAD_SIZE+`ADDR_BITS-1:0]  rd_data,
  output logic [CNTW-1:0]                      pkt_count,
  output logic                                 misroute,
  output logic                                 overflow
);
  localparam int AB  = `ADDR_BITS;
  localparam int FW  = `PAYLOAD_SIZE + `ADDR_BITS;
  localparam int BCW = $clog2(FW);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [AB-1:0] ID_ADDR = AB'(id);

  typedef enum logic [1:0] {IDLE, RECV, STORE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BCW-1:0]  r_bit_cnt;
  logic [FW-1:0]   r_shreg;
  logic [FW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW:0]     w_count_nxt;
  logic            r_busy;
  logic [CNTW-1:0] r_pkt_count;
  logic            r_misroute;
  logic            r_overflow;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_last_bit;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = rd_en & ~w_empty;
  // A pop in the STORE cycle frees the slot the frame needs, so a full FIFO still accepts it.
  assign w_push      = (r_state == STORE) & (~w_full | w_pop);
  assign w_last_bit  = (r_bit_cnt == BCW'(FW - 1));
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign busy      = r_busy;
  assign rd_valid  = ~w_empty;
  assign rd_data   = r_mem[r_rd_ptr];
  assign pkt_count = r_pkt_count;
  assign misroute  = r_misroute;
  assign overflow  = r_overflow;

  // Frame FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: wait for start bit, collect FW bits, spend one cycle storing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (serial_in) w_state_nxt = RECV;
      RECV:    if (w_last_bit) w_state_nxt = STORE;
      STORE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Deserializer: bits arrive LSB first and land at their final position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      case (r_state)
        IDLE: if (serial_in) r_bit_cnt <= '0;
        RECV: begin
          r_shreg[r_bit_cnt] <= serial_in;
          r_bit_cnt          <= w_last_bit ? '0 : r_bit_cnt + BCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Show-ahead FIFO storage and pointers; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shreg;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Link status: busy looks at next-cycle occupancy; the other flags are sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_pkt_count <= '0;
      r_misroute  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_busy <= (w_count_nxt == (AW+1)'(DEPTH)) |
                ((w_count_nxt == (AW+1)'(DEPTH - 1)) & (r_state != IDLE));
      if (w_push) begin
        r_pkt_count <= r_pkt_count + CNTW'(1);
        if (r_shreg[AB-1:0] != ID_ADDR) r_misroute <= 1'b1;
      end
      if ((r_state == STORE) && !w_push) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_sink_to_memory.sv
// Bench for serial_sink_to_memory: directed steps plus randomized frames against a queue model.
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif

module tb_serial_sink_to_memory;
  localparam int AB    = `ADDR_BITS;
  localparam int PS    = `PAYLOAD_SIZE;
  localparam int FW    = AB + PS;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam logic [AB-1:0] MY_ID = 4'd5;

  logic            clk = 1'b0;
  logic            reset;
  logic            serial_in;
  logic            busy;
  logic            rd_en;
  logic            rd_valid;
  logic [FW-1:0]   rd_data;
  logic [CNTW-1:0] pkt_count;
  logic            misroute;
  logic            overflow;

  always #5 clk = ~clk;

  serial_sink_to_memory #(.id(5), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .busy(busy), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .pkt_count(pkt_count),
    .misroute(misroute), .overflow(overflow)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: FIFO contents as a queue plus expected sticky flags.
  logic [FW-1:0] q[$];
  int            accepted;
  bit            exp_mis;
  bit            exp_ovf;
  logic          busy_at_store;
  logic          rv_before_store;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    chk({tag, ".pkt_count"}, 32'(pkt_count), 32'(CNTW'(accepted)));
    chk({tag, ".misroute"}, 32'(misroute), 32'(exp_mis));
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, ".pkt_count"}, 32'(pkt_count), 32'd0);
    chk({tag, ".misroute"}, 32'(misroute), 32'd0);
    chk({tag, ".overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    serial_in = 1'b0;
    rd_en     = 1'b0;
    #3;
    check_zero(tag);
    q.delete();
    accepted = 0;
    exp_mis  = 1'b0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, then compare.
  task automatic cyc(input logic sin, input logic ren, input bit store, input logic [FW-1:0] f);
    bit pop;
    serial_in = sin;
    rd_en     = ren;
    pop = ren && (q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) q.delete(0);
    if (store) begin
      if (q.size() < DEPTH) begin
        q.push_back(f);
        accepted++;
        if (f[AB-1:0] != MY_ID) exp_mis = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    check_all("cyc");
  endtask

  // mode 0: never read, 1: read only in the STORE cycle, 2: random reads.
  function automatic logic pick_ren(input int mode, input bit st);
    if (mode == 2) return 1'($urandom_range(0, 1));
    if (mode == 1) return st;
    return 1'b0;
  endfunction

  task automatic send_frame(input logic [PS-1:0] pl, input logic [AB-1:0] ds, input int mode);
    logic [FW-1:0] f;
    f = {pl, ds};
    cyc(1'b1, pick_ren(mode, 1'b0), 1'b0, f);
    for (int i = 0; i < FW; i++) cyc(f[i], pick_ren(mode, 1'b0), 1'b0, f);
    rv_before_store = rd_valid;
    // serial_in is don't-care during STORE, so toggle it randomly.
    cyc(1'($urandom_range(0, 1)), pick_ren(mode, 1'b1), 1'b1, f);
    busy_at_store = busy;
    cyc(1'b0, pick_ren(mode, 1'b0), 1'b0, f);
  endtask

  initial begin
    logic [FW-1:0] part;
    logic [FW-1:0] second;
    logic [AB-1:0] ds;
    reset = 1'b1; serial_in = 1'b0; rd_en = 1'b0;
    q.delete(); accepted = 0; exp_mis = 1'b0; exp_ovf = 1'b0;
    #6;
    check_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a frame discards it.
    part = 12'hABC;
    cyc(1'b1, 1'b0, 1'b0, part);
    for (int i = 0; i < 5; i++) cyc(part[i], 1'b0, 1'b0, part);
    do_reset("mid_reset");

    // Clean frame to our own address, with latency check.
    send_frame(8'h41, 4'h5, 0);
    chk("lat.rv_before_store", 32'(rv_before_store), 32'd0);
    chk("f1.rd_data", 32'(rd_data), 32'h415);
    chk("f1.pkt_count", 32'(pkt_count), 32'd1);
    chk("f1.misroute", 32'(misroute), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, '0);

    // Misrouted frame sets the sticky flag.
    send_frame(8'h42, 4'h3, 0);
    chk("f2.rd_data", 32'(rd_data), 32'h423);
    chk("f2.misroute", 32'(misroute), 32'd1);
    send_frame(8'h43, 4'h5, 0);
    chk("f3.misroute_sticky", 32'(misroute), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);

    // Fill without reading: busy, then overflow on a forced 5th frame.
    do_reset("rst_fill");
    send_frame(8'h01, 4'h5, 0);
    send_frame(8'h02, 4'h5, 0);
    chk("fill2.busy", 32'(busy_at_store), 32'd0);
    send_frame(8'h03, 4'h5, 0);
    chk("fill3.busy_at_store", 32'(busy_at_store), 32'd1);
    chk("fill3.busy_idle", 32'(busy), 32'd0);
    send_frame(8'h04, 4'h5, 0);
    chk("fill4.busy", 32'(busy_at_store), 32'd1);
    chk("fill4.overflow", 32'(overflow), 32'd0);
    send_frame(8'h05, 4'h5, 0);
    chk("fill5.overflow", 32'(overflow), 32'd1);
    chk("fill5.pkt_count", 32'(pkt_count), 32'd4);
    chk("fill5.head", 32'(rd_data), 32'h015);

    // Full FIFO with a pop in the STORE cycle still accepts the frame.
    do_reset("rst_full");
    for (int i = 0; i < 4; i++) send_frame(PS'(8'h10 + i), 4'h5, 0);
    second = q[1];
    send_frame(8'h20, 4'h5, 1);
    chk("fullpop.head", 32'(rd_data), 32'(second));
    chk("fullpop.overflow", 32'(overflow), 32'd0);
    chk("fullpop.pkt_count", 32'(pkt_count), 32'd5);
    chk("fullpop.busy", 32'(busy_at_store), 32'd1);

    // Drain, then read while empty.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("empty.rd_valid", 32'(rd_valid), 32'd0);

    // Random frames with interleaved reads to wrap the pointers.
    for (int n = 0; n < 12; n++) begin
      ds = ($urandom_range(0, 1) == 1) ? MY_ID : AB'($urandom);
      send_frame(PS'($urandom), ds, 2);
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("final.rd_valid", 32'(rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
